// File: rtl/period_meter.sv
// Measures the period of a slow asynchronous square wave in clk cycles.
// Reports the count between consecutive rising edges with a one-cycle strobe.
module period_meter #(
  parameter int CNT_W       = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rise_pulse_reg;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0]       period_reg, period_next;
  logic                   overflow_reg, overflow_next;
  logic                   period_valid_reg, period_valid_next;
  logic                   busy_reg, busy_next;
  logic                   sync_out;
  logic                   rise_det;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise_det = sync_out & ~prev_reg;

  // Input synchronizer, edge-history flop and registered edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg       <= '0;
      prev_reg       <= 1'b0;
      rise_pulse_reg <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      prev_reg       <= sync_out;
      rise_pulse_reg <= rise_det;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      period_reg       <= '0;
      overflow_reg     <= 1'b0;
      period_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      period_reg       <= period_next;
      overflow_reg     <= overflow_next;
      period_valid_reg <= period_valid_next;
      busy_reg         <= busy_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    period_next       = period_reg;
    overflow_next     = overflow_reg;
    period_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = ARM;
      end
      ARM: begin
        if (rise_det) begin
          cnt_next   = CNT_ONE;
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        // A closing edge beats saturation when both happen together
        if (rise_det || (cnt_reg == CNT_MAX)) begin
          period_valid_next = 1'b1;
          period_next       = cnt_reg;
          overflow_next     = ~rise_det;
          if (cont && rise_det) begin
            cnt_next = CNT_ONE;
          end else if (cont) begin
            state_next = ARM;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Busy stays up through the strobe cycle and drops the cycle after
    busy_next = (state_next != IDLE) | period_valid_next;
  end

  assign busy         = busy_reg;
  assign rise_pulse   = rise_pulse_reg;
  assign period       = period_reg;
  assign period_valid = period_valid_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 26-bit and an 8-bit instance share stimulus,
// each test starts from reset and checks only the relevant instance.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        busy_a, rise_a, pv_a, ovf_a;
  logic [25:0] period_a;
  logic        busy_b, rise_b, pv_b, ovf_b;
  logic [7:0]  period_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  period_meter #(.CNT_W(26), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy_a), .rise_pulse(rise_a), .period(period_a),
    .period_valid(pv_a), .overflow(ovf_a)
  );

  period_meter #(.CNT_W(8), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy_b), .rise_pulse(rise_b), .period(period_b),
    .period_valid(pv_b), .overflow(ovf_b)
  );

  // Strobe/pulse recorder, sampled mid-cycle
  int          n_pv_a = 0;
  int          n_rise_a = 0;
  int          n_pv_b = 0;
  int          busy_low_a = 0;
  logic        pv_a_d = 1'b0;
  logic        busy_at_pv = 1'b0;
  logic        busy_after_pv = 1'b0;
  logic [25:0] per_q_a[$];
  logic        ovf_q_a[$];

  always @(negedge clk) begin
    if (pv_a_d) busy_after_pv <= busy_a;
    pv_a_d <= pv_a;
    if (pv_a) begin
      n_pv_a <= n_pv_a + 1;
      per_q_a.push_back(period_a);
      ovf_q_a.push_back(ovf_a);
      busy_at_pv <= busy_a;
    end
    if (rise_a) n_rise_a <= n_rise_a + 1;
    if (!busy_a) busy_low_a <= busy_low_a + 1;
    if (pv_b) n_pv_b <= n_pv_b + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] per_at(input int idx);
    if (idx < per_q_a.size()) return 32'(per_q_a[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ovf_at(input int idx);
    if (idx < ovf_q_a.size()) return 32'(ovf_q_a[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sq(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) step();
    sig_in = 1'b0;
    repeat (lo) step();
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    sig_in = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bq, bp, br, bb, bl;

    // Single measurement of a 10-cycle square wave
    reset_dut();
    check_val("rst_busy", 32'(busy_a), 0);
    check_val("rst_rise", 32'(rise_a), 0);
    check_val("rst_pv", 32'(pv_a), 0);
    check_val("rst_ovf", 32'(ovf_a), 0);
    check_val("rst_period", 32'(period_a), 0);
    bp = n_pv_a; br = n_rise_a; bq = per_q_a.size();
    pulse_start();
    check_val("busy_after_start", 32'(busy_a), 1);
    sig_in = 1'b1;
    step(); check_val("rise_lat0", 32'(rise_a), 0);
    step(); check_val("rise_lat1", 32'(rise_a), 0);
    step(); check_val("rise_lat2", 32'(rise_a), 1);
    step(); check_val("rise_width", 32'(rise_a), 0);
    step();
    sig_in = 1'b0;
    repeat (5) step();
    sq(5, 5);
    sq(5, 5);
    repeat (5) step();
    check_val("p10_count", 32'(n_pv_a - bp), 1);
    check_val("p10_period", per_at(bq), 10);
    check_val("p10_ovf", ovf_at(bq), 0);
    check_val("p10_busy_at_pv", 32'(busy_at_pv), 1);
    check_val("p10_busy_after_pv", 32'(busy_after_pv), 0);
    check_val("p10_rise_count", 32'(n_rise_a - br), 3);
    check_val("p10_period_hold", 32'(period_a), 10);
    check_val("p10_idle", 32'(busy_a), 0);

    // Level high at arm time is not an edge; start while busy is ignored
    reset_dut();
    sig_in = 1'b1;
    repeat (3) step();
    bp = n_pv_a; bq = per_q_a.size();
    pulse_start();
    repeat (2) step();
    start = 1'b1; step(); start = 1'b0;
    step();
    sig_in = 1'b0;
    repeat (3) step();
    check_val("held_no_result", 32'(n_pv_a - bp), 0);
    check_val("held_busy", 32'(busy_a), 1);
    sig_in = 1'b1;
    repeat (2) step();
    start = 1'b1; step(); start = 1'b0;
    step();
    sig_in = 1'b0;
    repeat (4) step();
    sig_in = 1'b1;
    repeat (6) step();
    sig_in = 1'b0;
    repeat (4) step();
    check_val("held_count", 32'(n_pv_a - bp), 1);
    check_val("held_period", per_at(bq), 8);
    check_val("held_ovf", ovf_at(bq), 0);
    check_val("held_idle", 32'(busy_a), 0);

    // Saturation on the 8-bit instance
    reset_dut();
    bb = n_pv_b;
    pulse_start();
    sig_in = 1'b1;
    repeat (3) step();
    sig_in = 1'b0;
    for (int i = 0; i < 400 && n_pv_b == bb; i++) step();
    check_val("sat_strobe", 32'(n_pv_b - bb), 1);
    check_val("sat_period", 32'(period_b), 255);
    check_val("sat_ovf", 32'(ovf_b), 1);
    repeat (3) step();
    check_val("sat_idle", 32'(busy_b), 0);
    check_val("sat_single", 32'(n_pv_b - bb), 1);

    // Continuous mode, periods 10, 12, 10
    reset_dut();
    cont = 1'b1;
    bp = n_pv_a; bq = per_q_a.size();
    pulse_start();
    bl = busy_low_a;
    sq(5, 5);
    sq(6, 6);
    sq(5, 5);
    sig_in = 1'b1;
    repeat (5) step();
    check_val("cont_count", 32'(n_pv_a - bp), 3);
    check_val("cont_p0", per_at(bq), 10);
    check_val("cont_p1", per_at(bq + 1), 12);
    check_val("cont_p2", per_at(bq + 2), 10);
    check_val("cont_ovf", ovf_at(bq) | ovf_at(bq + 1) | ovf_at(bq + 2), 0);
    check_val("cont_busy_low", 32'(busy_low_a - bl), 0);
    check_val("cont_busy", 32'(busy_a), 1);

    // Asynchronous reset mid-measurement
    reset_dut();
    cont = 1'b1;
    bp = n_pv_a; bq = per_q_a.size();
    pulse_start();
    sq(5, 5);
    sig_in = 1'b1;
    repeat (6) step();
    check_val("pre_rst_period", per_at(bq), 10);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", 32'(busy_a), 0);
    check_val("arst_period", 32'(period_a), 0);
    check_val("arst_pv", 32'(pv_a), 0);
    check_val("arst_ovf", 32'(ovf_a), 0);
    check_val("arst_rise", 32'(rise_a), 0);
    bp = n_pv_a; bq = per_q_a.size();
    sig_in = 1'b0;
    cont = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("arst_no_strobe", 32'(n_pv_a - bp), 0);
    repeat (2) step();
    pulse_start();
    sq(10, 10);
    sig_in = 1'b1;
    repeat (4) step();
    check_val("p20_count", 32'(n_pv_a - bp), 1);
    check_val("p20_period", per_at(bq), 20);

    // Closing edge lands exactly on cnt == max (8-bit instance)
    reset_dut();
    bb = n_pv_b;
    pulse_start();
    sig_in = 1'b1;
    repeat (100) step();
    sig_in = 1'b0;
    repeat (155) step();
    sig_in = 1'b1;
    repeat (5) step();
    check_val("tie_count", 32'(n_pv_b - bb), 1);
    check_val("tie_period", 32'(period_b), 255);
    check_val("tie_ovf", 32'(ovf_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
